// File: rtl/exec_pkg.sv
// Shared types and op-decode helpers for the multi-cycle execute unit.
package exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,  OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,  OP_XOR  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA    = 5'd7,
    OP_OR     = 5'd8,  OP_AND  = 5'd9,
    OP_MUL    = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19,
    OP_DIV    = 5'd20, OP_DIVU = 5'd21, OP_REM  = 5'd22, OP_REMU   = 5'd23
  } exec_op_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic is_mul(exec_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(exec_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // {a_signed, b_signed}; MUL low half is sign-agnostic so it is treated as unsigned
  function automatic logic [1:0] is_signed(exec_op_t op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 2'b11;
      OP_MULHSU:               return 2'b10;
      default:                 return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// one bit per cycle, sign correction folded into the final iteration.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  exec_op_t        op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0]   mcand, mag_a, mag_b, q, r;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [CW-1:0]     cnt;
  logic [1:0]        sg;
  logic              run, div_q, hi_q, rem_q, neg_q, neg_r_q, sa, sb;

  assign sg    = is_signed(op);
  assign sa    = sg[1] & a[XLEN-1];
  assign sb    = sg[0] & b[XLEN-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // acc = {hi, lo}: mul keeps partial sum in hi, multiplier in lo;
  // div keeps partial remainder in hi, dividend/quotient in lo
  always_comb begin
    acc_nxt = acc;
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    if (div_q) begin
      rem_sh = acc[2*XLEN-1:XLEN-1];
      diff   = rem_sh - {1'b0, mcand};
      if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
  end

  assign prod   = neg_q ? -acc_nxt : acc_nxt;
  assign q      = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign r      = neg_r_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
  assign result = div_q ? (rem_q ? r : q) : (hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
  assign done   = run && (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0; cnt <= '0; acc <= '0; mcand <= '0;
      div_q <= 1'b0; hi_q <= 1'b0; rem_q <= 1'b0; neg_q <= 1'b0; neg_r_q <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run     <= 1'b1;
      cnt     <= '0;
      acc     <= {{XLEN{1'b0}}, mag_a};
      mcand   <= mag_b;
      div_q   <= is_div(op);
      hi_q    <= op inside {OP_MULH, OP_MULHSU, OP_MULHU};
      rem_q   <= op inside {OP_REM, OP_REMU};
      // divide-by-zero quotient stays all-ones, so never negate it
      neg_q   <= (sa ^ sb) && !(is_div(op) && b == '0);
      neg_r_q <= sa;
    end else if (run) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_mc.sv
// Multi-cycle execute unit: single-cycle ALU plus iterative M-extension
// engine behind a one-op-in-flight valid/ready handshake.
module execute_mc
  import exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_ALU = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  exec_op_t        op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);

  state_t          state, nxt;
  logic            accept, m_op, m_q, eng_start, eng_done, lt;
  logic [XLEN-1:0] alu_res, eng_res, fin_res;
  logic [SW-1:0]   shamt;

  assign m_op      = is_mul(op) || is_div(op);
  assign in_ready  = (state == S_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  // with FAST_ALU off, ALU ops ride the engine purely for its timing
  assign eng_start = accept && (m_op || !FAST_ALU);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign shamt     = b[SW-1:0];
  assign lt        = (op inside {OP_SLTU, OP_MULHU, OP_DIVU, OP_REMU}) ? (a < b)
                                                                     : ($signed(a) < $signed(b));

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = XLEN'($signed(a) < $signed(b));
      OP_SLTU: alu_res = XLEN'(a < b);
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .abort  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (eng_done),
    .result (eng_res)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:       if (accept) nxt = (!m_op && FAST_ALU) ? S_DONE
                                    : (is_div(op) ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (eng_done) nxt = S_DONE;
      S_DONE:       if (out_ready) nxt = S_IDLE;
      default:      nxt = S_IDLE;
    endcase
    if (flush) nxt = S_IDLE;
  end

  assign fin_res = m_q ? eng_res : result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      m_q    <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      less   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        m_q    <= m_op;
        less   <= lt;
        result <= alu_res;
        zero   <= (alu_res == '0);
      end else if (eng_done) begin
        result <= fin_res;
        zero   <= (fin_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc (XLEN=32): ALU/M-ext results, latency,
// divide corner cases, flush/reset abort, output stall and handoff.
module tb_execute_mc;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic        in_ready, out_valid, zero, less, busy;
  exec_op_t    op_i;
  logic [31:0] a_i, b_i, result;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  execute_mc #(.XLEN(32), .FAST_ALU(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op_i),
    .a(a_i), .b(b_i), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .less(less), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input exec_op_t o, input logic [31:0] x, y,
                        input logic [31:0] exp_r, input int exp_lat, input logic exp_z, exp_l);
    int lat, n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    in_valid = 1'b1; op_i = o; a_i = x; b_i = y;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, 64'(result), 64'(exp_r));
    chk({tag, " zero"}, 64'(zero), 64'(exp_z));
    chk({tag, " less"}, 64'(less), 64'(exp_l));
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    int ov;
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op_i = OP_ADD; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst result", 64'(result), 64'(0));
    chk("rst zero", 64'(zero), 64'(0));
    chk("rst less", 64'(less), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(1));

    run_op("ADD",   OP_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1, 1'b0, 1'b0);
    run_op("SUB",   OP_SUB,  32'd5,        32'd5,        32'h0,        1, 1'b1, 1'b0);
    run_op("SLT",   OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1, 1'b0, 1'b1);
    run_op("SLTU",  OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 1'b1, 1'b0);
    run_op("SLL",   OP_SLL,  32'd1,        32'd33,       32'd2,        1, 1'b0, 1'b1);
    run_op("SRL",   OP_SRL,  32'h80000000, 32'd31,       32'd1,        1, 1'b0, 1'b1);
    run_op("SRA",   OP_SRA,  32'h80000000, 32'h24,       32'hF8000000, 1, 1'b0, 1'b1);
    run_op("XOR",   OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 1'b0, 1'b1);
    run_op("OR",    OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1, 1'b0, 1'b1);
    run_op("AND",   OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 1'b0, 1'b1);
    run_op("BADOP", exec_op_t'(5'd12), 32'd3, 32'd4,    32'h0,        1, 1'b1, 1'b1);

    run_op("MULH",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0, 1'b0);
    run_op("MULHU",  OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0, 1'b0);
    run_op("MUL",    OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 33, 1'b1, 1'b0);
    run_op("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 1'b0, 1'b1);
    run_op("MULNEG", OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, 1'b0);

    run_op("DIV",    OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0, 1'b1);
    run_op("REM",    OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0, 1'b1);
    run_op("DIVU0",  OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 33, 1'b0, 1'b0);
    run_op("REMU0",  OP_REMU, 32'd5,        32'd0,        32'd5,        33, 1'b0, 1'b0);
    run_op("DIVOVF", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 1'b0, 1'b1);
    run_op("REMOVF", OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        33, 1'b1, 1'b1);
    run_op("DIV0",   OP_DIV,  32'd7,        32'd0,        32'hFFFFFFFF, 33, 1'b0, 1'b0);
    run_op("REM0",   OP_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 33, 1'b0, 1'b1);
    run_op("DIVU",   OP_DIVU, 32'd100,      32'd7,        32'd14,       33, 1'b0, 1'b0);
    run_op("REMU",   OP_REMU, 32'd100,      32'd7,        32'd2,        33, 1'b0, 1'b0);

    // flush in cycle 10 of a divide
    @(negedge clk);
    in_valid = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready low", 64'(in_ready), 64'(0));
    chk("flush busy before", 64'(busy), 64'(1));
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 64'(busy), 64'(0));
    chk("flush in_ready", 64'(in_ready), 64'(1));
    ov = 0;
    repeat (40) begin @(negedge clk); if (out_valid) ov++; end
    chk("flush no out_valid", 64'(ov), 64'(0));

    // reset in cycle 10 of a divide
    @(negedge clk);
    in_valid = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst mid busy", 64'(busy), 64'(0));
    chk("rst mid in_ready", 64'(in_ready), 64'(1));
    chk("rst mid result", 64'(result), 64'(0));
    ov = 0;
    repeat (40) begin @(negedge clk); if (out_valid) ov++; end
    chk("rst mid no out_valid", 64'(ov), 64'(0));

    // flush together with in_valid must not accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op_i = OP_ADD; a_i = 32'd1; b_i = 32'd1;
    #1 chk("flush+valid in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush+valid out_valid", 64'(out_valid), 64'(0));
    chk("flush+valid busy", 64'(busy), 64'(0));

    // output stall, then handoff with next op already waiting
    @(negedge clk);
    in_valid = 1'b1; op_i = OP_ADD; a_i = 32'd3; b_i = 32'd4;
    @(posedge clk); #1 op_i = OP_SUB; a_i = 32'd9; b_i = 32'd3;
    held = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall out_valid", 64'(out_valid), 64'(1));
      chk("stall result", 64'(result), 64'(held));
      chk("stall in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("handoff in_ready", 64'(in_ready), 64'(0));
    chk("handoff result", 64'(result), 64'(held));
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("after handoff in_ready", 64'(in_ready), 64'(1));
    chk("after handoff out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("next op out_valid", 64'(out_valid), 64'(1));
    chk("next op result", 64'(result), 64'(6));
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter FAST_ALU, default 1, meaning 1 = ALU ops bypass the iterative engine with latency 1; 0 = all ops use the DONE path.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  issue request.
REQ-006 SHALL have port in_ready  output  1  unit can accept an op.
REQ-007 SHALL have port op  input  5  operation code (exec_op_t).
REQ-008 SHALL have ports a, b  input  XLEN  source operands.
REQ-009 SHALL have port flush  input  1  abort any in-flight op.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  XLEN  op result.
REQ-013 SHALL have ports zero, less  output  1  result==0; signed a<b (SLTU-class ops: unsigned a<b).
REQ-014 SHALL have port busy  output  1  state != IDLE.

Function
REQ-015 SHALL support ops ADD SUB SLL SLT SLTU XOR SRL SRA OR AND MUL MULH MULHSU MULHU DIV DIVU REM REMU; other codes SHALL produce result 0.
REQ-016 Handshake: op accepted on a rising edge where in_valid && in_ready; in_ready SHALL equal (state==IDLE) && !flush.
REQ-017 FSM states: IDLE, MUL, DIV, DONE; IDLE->MUL/DIV on accepted M-op, IDLE->DONE on accepted ALU op, MUL/DIV->DONE after XLEN iterations, DONE->IDLE on out_ready.
REQ-018 Latency: op accepted in cycle t; ALU op out_valid first high in cycle t+1; M-ext op out_valid first high in cycle t+XLEN+1.
REQ-019 result, zero, less SHALL be held stable while out_valid && !out_ready.
REQ-020 A new op SHALL NOT be accepted in the same cycle as the DONE->IDLE handoff (no back-to-back overlap; one op in flight).
REQ-021 Shift amount SHALL use b[log2(XLEN)-1:0]; arithmetic wraps modulo 2^XLEN.
REQ-022 MUL: shift-add, one partial product per cycle, 2*XLEN accumulator; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits with signedness per op.
REQ-023 DIV/REM: restoring, one quotient bit per cycle on magnitudes, sign fixed in last cycle; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
REQ-024 Divide by zero: DIV/DIVU quotient all-ones, REM/REMU remainder = a; latency unchanged.
REQ-025 Signed overflow (a = most-negative, b = -1): DIV quotient = a, REM remainder = 0; latency unchanged.
REQ-026 flush in any state SHALL return to IDLE next edge, out_valid low next cycle, result discarded; flush with in_valid SHALL not accept.

Reset
REQ-027 On rst high at a rising edge: state=IDLE, out_valid=0, result=0, zero=0, less=0, busy=0, iteration counter=0.
REQ-028 rst mid-iteration SHALL abort the op with no result produced; rst has priority over flush and handshake.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-030 Package exec_pkg SHALL hold exec_op_t enum, state enum, and is_mul/is_div/is_signed helper functions.
REQ-031 Iterative multiply/divide datapath SHALL be sub-module muldiv_iter (start, op, a, b -> done, result); ALU logic stays in execute_mc.

Verification (XLEN=32)
REQ-032 ADD a=0x7FFFFFFF b=1 accepted cycle 0 -> out_valid cycle 1, result 0x80000000, zero 0.
REQ-033 MULH a=0x80000000 b=0x80000000 -> out_valid cycle 33, result 0x40000000; MULHU same operands -> 0x40000000; MUL -> 0x00000000, zero 1.
REQ-034 DIV a=-7 b=2 -> result 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF; REMU -> 5.
REQ-035 DIV a=0x80000000 b=0xFFFFFFFF -> result 0x80000000; REM -> 0; both at cycle 33.
REQ-036 DIVU accepted, flush at cycle 10 -> busy 0 and in_ready 1 at cycle 11, no out_valid ever; same with rst instead of flush.
REQ-037 ADD result with out_ready low for 5 cycles -> result/out_valid stable, in_ready 0 throughout; in_valid held -> next op accepted only after handoff cycle.
